// File: rtl/wb_tagged_ram.sv
// Wishbone classic slave RAM with one memory tag per granule, sub-word writes merged
// by read-modify-write, and sticky capture of the first tag-mismatch fault address.
module wb_tagged_ram #(
    parameter int    WB_DATA_WIDTH      = 32,
    parameter int    WB_ADDR_WIDTH      = 32,
    parameter int    WB_RAM_WORDS       = 256,
    parameter int    GRANULE_SIZE_BYTES = 16,
    parameter int    GRANULE_TAG_WIDTH  = 4,
    parameter int    TAG_LSB            = 26,
    parameter string WB_RAM_MEM_FILE    = ""
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic [WB_ADDR_WIDTH-1:0]   wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0]   wb_data_i,
    input  logic [WB_DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                       wb_we_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_tga_i,
    input  logic                       check_tags_i,
    input  logic                       abort_on_mismatch_i,
    input  logic                       clear_mismatch_i,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    output logic [WB_DATA_WIDTH-1:0]   wb_data_o,
    output logic                       tag_mismatch_o,
    output logic [WB_ADDR_WIDTH-1:0]   fault_addr_o
);

    localparam int BYTES    = WB_DATA_WIDTH / 8;
    localparam int BYTE_AW  = $clog2(BYTES);
    localparam int WORD_AW  = $clog2(WB_RAM_WORDS);
    localparam int GRANULES = WB_RAM_WORDS * BYTES / GRANULE_SIZE_BYTES;
    localparam int GRAN_OFF = $clog2(GRANULE_SIZE_BYTES);
    localparam int GRAN_AW  = $clog2(GRANULES);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} state_e;

    logic [WB_DATA_WIDTH-1:0]     mem     [WB_RAM_WORDS];
    logic [GRANULE_TAG_WIDTH-1:0] tag_mem [GRANULES];

    state_e                     state_q, state_d;
    logic [WB_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WB_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BYTES-1:0]           sel_q, sel_d;
    logic                       we_q, we_d;
    logic                       tga_q, tga_d;
    logic                       ack_q, ack_d;
    logic                       err_q, err_d;
    logic [WB_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                       flag_q, flag_d;
    logic [WB_ADDR_WIDTH-1:0]   fault_q, fault_d;

    logic [WB_DATA_WIDTH-1:0]     word_q;
    logic [GRANULE_TAG_WIDTH-1:0] tag_q;
    logic [WB_DATA_WIDTH-1:0]     merged;
    logic                         req;
    logic                         mismatch;
    logic                         abort;
    logic                         mem_we;
    logic                         tag_we;

    assign req = (state_q == S_IDLE) && wb_cyc_i && wb_stb_i;

    // NOTE: the arrays and their read registers have no reset; only control state does.
    always_ff @(posedge wb_clk_i) begin
        if (req) begin
            word_q <= mem[wb_addr_i[BYTE_AW +: WORD_AW]];
            tag_q  <= tag_mem[wb_addr_i[GRAN_OFF +: GRAN_AW]];
        end
        if (mem_we) mem[addr_q[BYTE_AW +: WORD_AW]] <= merged;
        if (tag_we) tag_mem[addr_q[GRAN_OFF +: GRAN_AW]] <= wdata_q[GRANULE_TAG_WIDTH-1:0];
    end

    always_comb begin
        merged = word_q;
        for (int i = 0; i < BYTES; i++) begin
            if (sel_q[i]) merged[i*8 +: 8] = wdata_q[i*8 +: 8];
        end
    end

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        we_d     = we_q;
        tga_d    = tga_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = '0;
        flag_d   = clear_mismatch_i ? 1'b0 : flag_q;
        fault_d  = fault_q;
        mismatch = 1'b0;
        abort    = 1'b0;
        mem_we   = 1'b0;
        tag_we   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = wb_addr_i;
                    wdata_d = wb_data_i;
                    sel_d   = wb_sel_i;
                    we_d    = wb_we_i;
                    tga_d   = wb_tga_i;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_d = S_IDLE;
                if (wb_cyc_i) begin
                    state_d  = S_RESP;
                    mismatch = check_tags_i && !tga_q &&
                               (addr_q[TAG_LSB +: GRANULE_TAG_WIDTH] != tag_q);
                    abort    = mismatch && abort_on_mismatch_i;
                    mem_we   = we_q && !tga_q && !abort;
                    tag_we   = we_q && tga_q && !abort;
                    ack_d    = !abort;
                    err_d    = abort;
                    rdata_d  = tga_q ? WB_DATA_WIDTH'(tag_q) : word_q;
                    // A new fault overrides a simultaneous clear and re-arms the capture.
                    if (mismatch) begin
                        flag_d = 1'b1;
                        if (!flag_q || clear_mismatch_i) fault_d = addr_q;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            tga_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            flag_q  <= 1'b0;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            tga_q   <= tga_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            flag_q  <= flag_d;
            fault_q <= fault_d;
        end
    end

    assign wb_ack_o       = ack_q;
    assign wb_err_o       = err_q;
    assign wb_data_o      = rdata_q;
    assign tag_mismatch_o = flag_q;
    assign fault_addr_o   = fault_q;

endmodule

// File: tb/tb_wb_tagged_ram.sv
// Self-checking bench for wb_tagged_ram: vector table through a response scoreboard,
// plus hand sequences for abandon, reset mid-response and reset before the write edge.
module tb_wb_tagged_ram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  sel = '0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0, tga = 1'b0;
    logic        chk = 1'b0, abt = 1'b0, clr = 1'b0;

    logic        ack32, err32, flag32;
    logic [31:0] rd32, fault32;
    logic        ack64, err64, flag64;
    logic [63:0] rd64;
    logic [31:0] fault64;

    wb_tagged_ram u_dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_addr_i(addr), .wb_data_i(wdata[31:0]),
        .wb_sel_i(sel[3:0]), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_tga_i(tga),
        .check_tags_i(chk), .abort_on_mismatch_i(abt), .clear_mismatch_i(clr),
        .wb_ack_o(ack32), .wb_err_o(err32), .wb_data_o(rd32),
        .tag_mismatch_o(flag32), .fault_addr_o(fault32)
    );

    wb_tagged_ram #(.WB_DATA_WIDTH(64)) u_dut64 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_addr_i(addr), .wb_data_i(wdata),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_tga_i(tga),
        .check_tags_i(chk), .abort_on_mismatch_i(abt), .clear_mismatch_i(clr),
        .wb_ack_o(ack64), .wb_err_o(err64), .wb_data_o(rd64),
        .tag_mismatch_o(flag64), .fault_addr_o(fault64)
    );

    typedef struct {
        bit          wide;
        bit          we;
        bit          tga;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  sel;
        bit          chk;
        bit          abt;
        bit          clr;
        bit          exp_ack;
        bit          cmp_data;
        logic [63:0] exp_data;
        bit          exp_flag;
        logic [31:0] exp_fault;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit wide, bit we_v, bit tga_v, logic [31:0] a, logic [63:0] d,
                                logic [7:0] s, bit c, bit ab, bit cl, bit eack, bit cmpd,
                                logic [63:0] ed, bit ef, logic [31:0] efa);
        vec_t v;
        v.wide = wide; v.we = we_v; v.tga = tga_v; v.addr = a; v.data = d; v.sel = s;
        v.chk = c; v.abt = ab; v.clr = cl; v.exp_ack = eack; v.cmp_data = cmpd;
        v.exp_data = ed; v.exp_flag = ef; v.exp_fault = efa;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        vec_t e;
        int   lat;
        bit   got;
        logic r_ack, r_err;
        logic [63:0] r_data;
        sb.push_back(v);
        @(negedge clk);
        addr = v.addr; wdata = v.data; sel = v.sel; we = v.we; tga = v.tga;
        chk = v.chk; abt = v.abt; cyc = 1'b1; stb = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            clr = v.clr && (lat == 1);
            got = v.wide ? (ack64 | err64) : (ack32 | err32);
        end
        clr = 1'b0;
        r_ack  = v.wide ? ack64 : ack32;
        r_err  = v.wide ? err64 : err32;
        r_data = v.wide ? rd64 : {32'h0, rd32};
        e = sb.pop_front();
        check($sformatf("v%0d latency", idx), 64'(lat), 64'd2);
        check($sformatf("v%0d ack", idx), 64'(r_ack), 64'(e.exp_ack));
        check($sformatf("v%0d err", idx), 64'(r_err), 64'(!e.exp_ack));
        if (e.cmp_data) check($sformatf("v%0d data", idx), r_data, e.exp_data);
        if (!e.wide) begin
            check($sformatf("v%0d flag", idx), 64'(flag32), 64'(e.exp_flag));
            check($sformatf("v%0d fault", idx), 64'(fault32), 64'(e.exp_fault));
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; tga = 1'b0; chk = 1'b0; abt = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int   lat;
        bit   seen;
        logic [63:0] wd64;

        //            wide we tga addr          data                   sel   chk abt clr ack cmp exp_data               flg fault
        vecs.push_back(mk(0, 1, 0, 32'h40,       64'hDEADBEEF,          8'hF, 0, 0, 0, 1, 0, 64'h0,                 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h40,       64'h0,                 8'hF, 0, 0, 0, 1, 1, 64'hDEADBEEF,          0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h80,       64'h11223344,          8'hF, 0, 0, 0, 1, 0, 64'h0,                 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h80,       64'hAABBCCDD,          8'h5, 0, 0, 0, 1, 0, 64'h0,                 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h80,       64'h0,                 8'hF, 0, 0, 0, 1, 1, 64'h11BB33DD,          0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h84,       64'h01020304,          8'hF, 0, 0, 0, 1, 0, 64'h0,                 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h84,       64'hFFFFFFFF,          8'h0, 0, 0, 0, 1, 0, 64'h0,                 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h84,       64'h0,                 8'hF, 0, 0, 0, 1, 1, 64'h01020304,          0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h40,       64'h5A000000,          8'h8, 0, 0, 0, 1, 0, 64'h0,                 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h40,       64'h0,                 8'hF, 0, 0, 0, 1, 1, 64'h5AADBEEF,          0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h400,      64'hCAFEF00D,          8'hF, 0, 0, 0, 1, 0, 64'h0,                 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        64'h0,                 8'hF, 0, 0, 0, 1, 1, 64'hCAFEF00D,          0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h100,      64'hFFFFFFF7,          8'hF, 0, 0, 0, 1, 0, 64'h0,                 0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h10C,      64'h0,                 8'hF, 0, 0, 0, 1, 1, 64'h7,                 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h100,      64'h12345678,          8'hF, 0, 0, 0, 1, 0, 64'h0,                 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h1C000100, 64'h0,                 8'hF, 1, 1, 0, 1, 1, 64'h12345678,          0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0C000100, 64'h99999999,          8'hF, 1, 1, 0, 0, 0, 64'h0,                 1, 32'h0C000100));
        vecs.push_back(mk(0, 0, 0, 32'h100,      64'h0,                 8'hF, 0, 0, 0, 1, 1, 64'h12345678,          1, 32'h0C000100));
        vecs.push_back(mk(0, 0, 0, 32'h0C000104, 64'h0,                 8'hF, 1, 1, 0, 0, 0, 64'h0,                 1, 32'h0C000100));
        vecs.push_back(mk(0, 0, 0, 32'h0C000108, 64'h0,                 8'hF, 1, 1, 1, 0, 0, 64'h0,                 1, 32'h0C000108));
        vecs.push_back(mk(0, 0, 0, 32'h100,      64'h0,                 8'hF, 0, 0, 1, 1, 1, 64'h12345678,          0, 32'h0C000108));
        vecs.push_back(mk(0, 1, 0, 32'h0C000100, 64'h55667788,          8'hF, 1, 0, 0, 1, 0, 64'h0,                 1, 32'h0C000100));
        vecs.push_back(mk(0, 0, 0, 32'h100,      64'h0,                 8'hF, 0, 0, 0, 1, 1, 64'h55667788,          1, 32'h0C000100));
        vecs.push_back(mk(1, 1, 0, 32'h8,        64'h1122334455667788,  8'hFF, 0, 0, 0, 1, 0, 64'h0,                0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h8,        64'hAABBCCDDEEFF0011,  8'h81, 0, 0, 0, 1, 0, 64'h0,                0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h8,        64'h0,                 8'hFF, 0, 0, 0, 1, 1, 64'hAA22334455667711, 0, 32'h0));

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset ack", 64'(ack32), 64'd0);
        check("reset err", 64'(err32), 64'd0);
        check("reset data", 64'(rd32), 64'd0);
        check("reset flag", 64'(flag32), 64'd0);
        check("reset fault", 64'(fault32), 64'd0);

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Master drops cyc while the access is in LOOKUP.
        @(negedge clk);
        addr = 32'h40; wdata = 64'hBAD0BAD0; sel = 8'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            seen = seen | ack32 | err32;
        end
        check("abandon response", 64'(seen), 64'd0);
        run_vec(100, mk(0, 0, 0, 32'h40, 64'h0, 8'hF, 0, 0, 0, 1, 1, 64'h5AADBEEF, 1, 32'h0C000100));

        // Asynchronous reset while ack is high.
        @(negedge clk);
        addr = 32'h40; sel = 8'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        lat = 0;
        while (!ack32 && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("rst_resp latency", 64'(lat), 64'd2);
        check("rst_resp data before", 64'(rd32), 64'h5AADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_resp ack", 64'(ack32), 64'd0);
        check("rst_resp err", 64'(err32), 64'd0);
        check("rst_resp data", 64'(rd32), 64'd0);
        check("rst_resp flag", 64'(flag32), 64'd0);
        check("rst_resp fault", 64'(fault32), 64'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted between the request edge and the write edge.
        wd64 = 64'h0BADF00D;
        @(negedge clk);
        addr = 32'h40; wdata = wd64; sel = 8'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(101, mk(0, 0, 0, 32'h40, 64'h0, 8'hF, 0, 0, 0, 1, 1, 64'h5AADBEEF, 0, 32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
